alu_ctrl_seq: RTL and testbench

- Parametrised, registered ALU control unit. Decodes the 3-bit main-decoder op and the 6-bit R-type funct into an ALC_W-bit ALU control word.
- Adds mult/div encodings plus a multi-cycle sequencer. The sequencer issues a start pulse to the iterative mult/div unit and stalls the pipeline for a programmable latency.
- Sits between the main control decoder and the EX stage ALU / mult-div unit.

---
 rtl/alu_ctrl_seq.sv | 193 +++++++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control unit with a multi-cycle mult/div sequencer.
//
// Decodes the main-decoder op class and the R-type funct field into an ALC_W-bit
// ALU control word (4-bit codes zero-extended). A mult/div issue sends a one-cycle
// start pulse to the iterative unit and holds the pipeline for MULDIV_LAT cycles,
// then pulses md_done.
//
// Optional feature macro: ALU_CTRL_SEQ_ILLEGAL_TRAP_EN
//   defined   : illegal op/funct raises illegal_out alongside valid_out
//   undefined : illegal_out tied to 0, illegal encodings decode to 0000 silently
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   valid_in     op/funct valid from decode
//   op, funct    main-decoder ALU op class, R-type function field
//   stall_in     downstream hold; freezes the output register
//   stall_out    upstream hold = stall_in | busy (combinational)
//   alc_out      registered ALU control word
//   valid_out    alc_out is valid
//   md_start     one-cycle mult/div issue pulse
//   md_op        0 = mult, 1 = div; registered with md_start
//   busy         sequencer waiting on the mult/div unit
//   md_done      one-cycle pulse at the end of the wait
//   illegal_out  undefined op/funct flag
module alu_ctrl_seq #(
  parameter int unsigned ALC_W      = 4,
  parameter int unsigned MULDIV_LAT = 32,
  parameter int unsigned CNT_W      = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [2:0]       op,
  input  logic [5:0]       funct,
  input  logic             stall_in,
  output logic             stall_out,
  output logic [ALC_W-1:0] alc_out,
  output logic             valid_out,
  output logic             md_start,
  output logic             md_op,
  output logic             busy,
  output logic             md_done,
  output logic             illegal_out
);

  localparam logic [3:0] AlcAdd  = 4'b0000;
  localparam logic [3:0] AlcSub  = 4'b0001;
  localparam logic [3:0] AlcSrl  = 4'b0010;
  localparam logic [3:0] AlcSlt  = 4'b0011;
  localparam logic [3:0] AlcAnd  = 4'b0100;
  localparam logic [3:0] AlcOr   = 4'b0101;
  localparam logic [3:0] AlcOp6  = 4'b0110;
  localparam logic [3:0] AlcXor  = 4'b0111;
  localparam logic [3:0] AlcMult = 4'b1000;
  localparam logic [3:0] AlcDiv  = 4'b1001;
  localparam logic [3:0] AlcSll  = 4'b1010;

  typedef enum logic {StIdle, StWait} seq_state_e;

  logic [3:0]       dec_code;
  logic             dec_illegal;
  logic             dec_is_md;
  logic             accept;

  seq_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             md_start_q;
  logic             md_op_q;
  logic             md_done_q;
  logic [ALC_W-1:0] alc_q;
  logic             valid_q;

  // Decode
  always_comb begin
    dec_code    = AlcAdd;
    dec_illegal = 1'b0;
    case (op)
      3'b000: dec_code = AlcAdd;
      3'b001: dec_code = AlcSub;
      3'b011: dec_code = AlcSrl;
      3'b100: dec_code = AlcAnd;
      3'b101: dec_code = AlcOr;
      3'b110: dec_code = AlcOp6;
      3'b010: begin
        case (funct)
          6'd0:    dec_code = AlcSll;
          6'd2:    dec_code = AlcSrl;
          6'd24:   dec_code = AlcMult;
          6'd26:   dec_code = AlcDiv;
          6'd32:   dec_code = AlcAdd;
          6'd34:   dec_code = AlcSub;
          6'd36:   dec_code = AlcAnd;
          6'd37:   dec_code = AlcOr;
          6'd38:   dec_code = AlcXor;
          6'd42:   dec_code = AlcSlt;
          default: begin
            dec_code    = AlcAdd;
            dec_illegal = 1'b1;
          end
        endcase
      end
      default: begin
        dec_code    = AlcAdd;
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Illegal encodings already decode to 0000, so they can never look like mult/div.
  assign dec_is_md = (dec_code == AlcMult) || (dec_code == AlcDiv);

  assign stall_out = stall_in | busy_q;
  assign accept    = valid_in & ~stall_out;

  // Output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alc_q   <= '0;
      valid_q <= 1'b0;
    end else if (accept) begin
      alc_q   <= ALC_W'(dec_code);
      valid_q <= 1'b1;
    end else if (!stall_in) begin
      valid_q <= 1'b0;
    end
  end

  // Mult/div sequencer: the counter runs regardless of stall_in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      md_start_q <= 1'b0;
      md_op_q    <= 1'b0;
      md_done_q  <= 1'b0;
    end else begin
      md_start_q <= 1'b0;
      md_done_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept && dec_is_md) begin
            state_q    <= StWait;
            md_start_q <= 1'b1;
            md_op_q    <= funct[1];
            cnt_q      <= CNT_W'(MULDIV_LAT - 1);
            busy_q     <= 1'b1;
          end
        end
        StWait: begin
          if (cnt_q == '0) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            md_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef ALU_CTRL_SEQ_ILLEGAL_TRAP_EN
  logic illegal_q;

  // Follows the same load/hold/clear rules as valid_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else if (accept) begin
      illegal_q <= dec_illegal;
    end else if (!stall_in) begin
      illegal_q <= 1'b0;
    end
  end

  assign illegal_out = illegal_q;
`else
  logic unused_dec_illegal;
  assign unused_dec_illegal = dec_illegal;
  assign illegal_out        = 1'b0;
`endif

  assign alc_out   = alc_q;
  assign valid_out = valid_q;
  assign md_start  = md_start_q;
  assign md_op     = md_op_q;
  assign busy      = busy_q;
  assign md_done   = md_done_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Randomised and directed bench for alu_ctrl_seq against a cycle-indexed reference
// model: a mult/div issued on edge k keeps busy high after edges k..k+LAT-1 and
// pulses md_done after edge k+LAT.
module tb_alu_ctrl_seq;

  localparam int unsigned ALC_W = 4;
  localparam int          LAT   = 3;
  localparam int unsigned CNT_W = 3;
`ifdef ALU_CTRL_SEQ_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             valid_in = 1'b0;
  logic [2:0]       op = '0;
  logic [5:0]       funct = '0;
  logic             stall_in = 1'b0;
  logic             stall_out;
  logic [ALC_W-1:0] alc_out;
  logic             valid_out;
  logic             md_start;
  logic             md_op;
  logic             busy;
  logic             md_done;
  logic             illegal_out;

  int total = 0;
  int bad   = 0;

  alu_ctrl_seq #(
    .ALC_W      (ALC_W),
    .MULDIV_LAT (LAT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_in    (valid_in),
    .op          (op),
    .funct       (funct),
    .stall_in    (stall_in),
    .stall_out   (stall_out),
    .alc_out     (alc_out),
    .valid_out   (valid_out),
    .md_start    (md_start),
    .md_op       (md_op),
    .busy        (busy),
    .md_done     (md_done),
    .illegal_out (illegal_out)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int k   = 0;      // edges since reset
  int iss = -1000;  // edge of the latest mult/div issue
  int m_alc = 0;
  bit m_valid = 0;
  bit m_ill = 0;
  bit m_mdop = 0;

  function automatic bit m_busy(int kk);
    return (kk >= iss) && (kk < iss + LAT);
  endfunction

  // Returns {illegal, code}
  function automatic int decode(int o, int f);
    int t[int];
    t[0] = 10; t[2] = 2; t[24] = 8; t[26] = 9; t[32] = 0;
    t[34] = 1; t[36] = 4; t[37] = 5; t[38] = 7; t[42] = 3;
    case (o)
      0: return 0;
      1: return 1;
      3: return 2;
      4: return 4;
      5: return 5;
      6: return 6;
      2: return t.exists(f) ? t[f] : 16;
      default: return 16;
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        k = 0; iss = -1000; m_alc = 0; m_valid = 0; m_ill = 0; m_mdop = 0;
      end else begin
        int d;
        bit acc;
        k++;
        acc = valid_in && !(stall_in || m_busy(k - 1));
        d   = decode(int'(op), int'(funct));
        if (acc) begin
          m_alc   = d % 16;
          m_valid = 1;
          m_ill   = TRAP && (d >= 16);
          if (m_alc == 8 || m_alc == 9) begin
            iss    = k;
            m_mdop = funct[1];
          end
        end else if (!stall_in) begin
          m_valid = 0;
          m_ill   = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk);
      chk("alc_out", int'(alc_out), m_alc);
      chk("valid_out", int'(valid_out), int'(m_valid));
      chk("illegal_out", int'(illegal_out), int'(m_ill));
      chk("busy", int'(busy), int'(m_busy(k)));
      chk("stall_out", int'(stall_out), int'(stall_in | m_busy(k)));
      chk("md_start", int'(md_start), int'(k == iss));
      chk("md_done", int'(md_done), int'(k == iss + LAT));
      if (k == iss) chk("md_op", int'(md_op), int'(m_mdop));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit v, input int o, input int f, input bit s);
    valid_in = v;
    op       = 3'(o);
    funct    = 6'(f);
    stall_in = s;
  endtask

  initial begin
    int fs[8] = '{32, 34, 36, 37, 38, 42, 0, 2};
    int es[8] = '{0, 1, 4, 5, 7, 3, 10, 2};
    int legal_f[10] = '{0, 2, 24, 26, 32, 34, 36, 37, 38, 42};
    int n;

    tick();
    tick();
    chk("reset alc_out", int'(alc_out), 0);
    chk("reset valid_out", int'(valid_out), 0);
    chk("reset busy", int'(busy), 0);
    rst_n = 1'b1;
    tick();

    // R-type sweep
    for (int i = 0; i < 8; i++) begin
      drive(1, 2, fs[i], 0);
      tick();
      chk("sweep alc_out", int'(alc_out), es[i]);
      chk("sweep valid_out", int'(valid_out), 1);
    end

    // Mult issue
    drive(1, 2, 24, 0);
    tick();
    drive(0, 0, 0, 0);
    chk("mult alc_out", int'(alc_out), 8);
    chk("mult md_start", int'(md_start), 1);
    chk("mult md_op", int'(md_op), 0);
    for (int i = 0; i < LAT; i++) begin
      chk("mult busy", int'(busy), 1);
      chk("mult stall_out", int'(stall_out), 1);
      chk("mult md_done early", int'(md_done), 0);
      tick();
    end
    chk("mult busy fall", int'(busy), 0);
    chk("mult md_done", int'(md_done), 1);
    tick();
    chk("mult md_done pulse", int'(md_done), 0);

    // Div back-to-back, held on valid_in
    drive(1, 2, 26, 0);
    tick();
    chk("div1 md_start", int'(md_start), 1);
    chk("div1 md_op", int'(md_op), 1);
    n = 0;
    do begin
      tick();
      n++;
    end while (!md_start && n < 20);
    drive(0, 0, 0, 0);
    chk("div2 spacing", n, LAT + 1);
    chk("div2 md_op", int'(md_op), 1);
    repeat (LAT + 2) tick();

    // Downstream stall
    drive(1, 2, 32, 0);
    tick();
    drive(1, 2, 34, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall alc_out", int'(alc_out), 0);
      chk("stall valid_out", int'(valid_out), 1);
    end
    drive(1, 2, 34, 0);
    tick();
    drive(0, 0, 0, 0);
    chk("post-stall alc_out", int'(alc_out), 1);
    chk("post-stall valid_out", int'(valid_out), 1);
    tick();

    // Illegal encodings
    drive(1, 7, 0, 0);
    tick();
    chk("ill op alc_out", int'(alc_out), 0);
    chk("ill op illegal_out", int'(illegal_out), int'(TRAP));
    drive(1, 2, 63, 0);
    tick();
    drive(0, 0, 0, 0);
    chk("ill funct alc_out", int'(alc_out), 0);
    chk("ill funct illegal_out", int'(illegal_out), int'(TRAP));
    chk("ill md_start", int'(md_start), 0);
    tick();

    // Reset mid-WAIT
    drive(1, 2, 24, 0);
    tick();
    drive(0, 0, 0, 0);
    tick();
    #1 rst_n = 1'b0;
    #1;
    chk("rst busy", int'(busy), 0);
    chk("rst md_done", int'(md_done), 0);
    chk("rst valid_out", int'(valid_out), 0);
    chk("rst alc_out", int'(alc_out), 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < LAT + 2; i++) begin
      tick();
      chk("rst no md_done", int'(md_done), 0);
    end

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      int o, f;
      o = int'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) f = legal_f[$urandom_range(0, 9)];
      else f = int'($urandom_range(0, 63));
      if ($urandom_range(0, 2) == 0) o = 2;
      drive($urandom_range(0, 9) < 7, o, f, $urandom_range(0, 4) == 0);
      tick();
    end

    drive(0, 0, 0, 0);
    repeat (LAT + 3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
